// File: rtl/pl_pkg.sv
// Shared definitions for the memory-access pipeline stage: FSM state
// encodings and the datapath / register-index widths.
package pl_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pl_reg_mw.sv
// M/W pipeline register. "bubble" clears only the write controls and leaves
// the data fields alone; "load" captures the M-stage fields, and wmo is only
// refreshed from the load buffer when load_mo is also set.
module pl_reg_mw
    import pl_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic              bubble,
    input  logic              load_mo,
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic [DATA_W-1:0] mal,
    input  logic [REG_W-1:0]  mrd,
    input  logic [DATA_W-1:0] load_buf,
    output logic              wwreg,
    output logic              wm2reg,
    output logic [DATA_W-1:0] wmo,
    output logic [DATA_W-1:0] wal,
    output logic [REG_W-1:0]  wrd
);

    // W-stage register: async clear, bubble has priority over load
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
            wmo    <= '0;
            wal    <= '0;
            wrd    <= '0;
        end else if (bubble) begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
        end else if (load) begin
            wwreg  <= mwreg;
            wm2reg <= mm2reg;
            wal    <= mal;
            wrd    <= mrd;
            if (load_mo) begin
                wmo <= load_buf;
            end
        end
    end

endmodule

// File: rtl/pl_mem_access.sv
// Memory-access pipeline stage. A three-state FSM issues one data-memory
// request per M-stage load/store, stalls the front of the pipe until the
// access completes, and then hands the result to the W-stage register.
module pl_mem_access
    import pl_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic              mwmem,
    input  logic [DATA_W-1:0] mal,
    input  logic [DATA_W-1:0] md,
    input  logic [REG_W-1:0]  mrd,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              mstall,
    output logic              wwreg,
    output logic              wm2reg,
    output logic [DATA_W-1:0] wmo,
    output logic [DATA_W-1:0] wal,
    output logic [REG_W-1:0]  wrd
);

    state_t            state;
    state_t            next_state;
    logic              mem_op;
    logic              w_load;
    logic              w_bubble;
    logic              w_load_mo;
    logic [DATA_W-1:0] load_buf;

    // A store wins when both load and store controls are set.
    assign mem_op = mm2reg | mwmem;

    // Request payload comes straight from the held M-stage inputs.
    assign dm_addr  = mal;
    assign dm_wdata = md;

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: grant moves a store to DONE, a load to WAIT for data
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (mem_op && dm_gnt) begin
                    next_state = mwmem ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (dm_rvalid) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: request/stall and W-register load/bubble selects per state
    always_comb begin
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        mstall    = 1'b0;
        w_load    = 1'b0;
        w_bubble  = 1'b0;
        w_load_mo = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    dm_req   = 1'b1;
                    dm_we    = mwmem;
                    mstall   = 1'b1;
                    w_bubble = 1'b1;
                end else begin
                    w_load = 1'b1;
                end
            end
            WAIT: begin
                mstall   = 1'b1;
                w_bubble = 1'b1;
            end
            DONE: begin
                w_load    = 1'b1;
                w_load_mo = 1'b1;
            end
            default: begin
                w_bubble = 1'b1;
            end
        endcase
    end

    // Load buffer: read data is only accepted while waiting for it
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            load_buf <= '0;
        end else if (state == WAIT && dm_rvalid) begin
            load_buf <= dm_rdata;
        end
    end

    pl_reg_mw u_reg_mw (
        .clk      (clk),
        .clr      (clr),
        .load     (w_load),
        .bubble   (w_bubble),
        .load_mo  (w_load_mo),
        .mwreg    (mwreg),
        .mm2reg   (mm2reg),
        .mal      (mal),
        .mrd      (mrd),
        .load_buf (load_buf),
        .wwreg    (wwreg),
        .wm2reg   (wm2reg),
        .wmo      (wmo),
        .wal      (wal),
        .wrd      (wrd)
    );

endmodule

// File: tb/tb_pl_mem_access.sv
// Scoreboard bench for pl_mem_access: a driver issues instructions, a memory
// responder plays the data memory, and a monitor checks W-stage results.
module tb_pl_mem_access;

    typedef struct {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] al;
        logic [31:0] d;
        logic [4:0]  rd;
        logic [31:0] rdata;
    } instr_t;

    typedef struct {
        int          gw;
        int          rw;
        logic [31:0] rdata;
    } cfg_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] mal, md;
    logic [4:0]  mrd;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mstall;
    logic        wwreg, wm2reg;
    logic [31:0] wmo, wal;
    logic [4:0]  wrd;

    instr_t exp_q[$];
    cfg_t   cfg_q[$];
    req_t   req_q[$];

    int nerr   = 0;
    int ncheck = 0;
    bit busy = 0;
    bit spur_en = 0;
    bit spur_force = 0;
    bit pend = 0;

    pl_mem_access dut (
        .clk       (clk),
        .clr       (clr),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mwmem     (mwmem),
        .mal       (mal),
        .md        (md),
        .mrd       (mrd),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mstall    (mstall),
        .wwreg     (wwreg),
        .wm2reg    (wm2reg),
        .wmo       (wmo),
        .wal       (wal),
        .wrd       (wrd)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
        ncheck++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one instruction onto the M-stage inputs and queue its expectations.
    task automatic drive_instr(input instr_t t, input int gw, input int rw);
        cfg_t c;
        req_t r;
        busy   = 1;
        mwreg  = t.wreg;
        mm2reg = t.m2reg;
        mwmem  = t.wmem;
        mal    = t.al;
        md     = t.d;
        mrd    = t.rd;
        exp_q.push_back(t);
        if (t.m2reg || t.wmem) begin
            c.gw = gw; c.rw = rw; c.rdata = t.rdata;
            cfg_q.push_back(c);
            r.we = t.wmem; r.addr = t.al; r.wdata = t.d;
            req_q.push_back(r);
        end
    endtask

    // Count stall cycles until the instruction retires, then step to the next cycle.
    task automatic wait_done(input int exp_stall, input string name);
        int  stalls = 0;
        bit  done = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!mstall) begin
                done = 1;
                break;
            end
            stalls++;
        end
        if (!done) chk({name, "_timeout"}, 104'd1, 104'd0);
        else       chk({name, "_stall_cycles"}, 104'(stalls), 104'(exp_stall));
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input instr_t t, input int gw, input int rw, input string name);
        int st;
        if (t.wmem)       st = gw + 1;
        else if (t.m2reg) st = gw + 2 + rw;
        else              st = 0;
        drive_instr(t, gw, rw);
        wait_done(st, name);
    endtask

    function automatic instr_t mk(input logic wr, input logic ld, input logic st,
                                  input logic [31:0] al, input logic [31:0] d,
                                  input logic [4:0] rd, input logic [31:0] rdata);
        instr_t t;
        t.wreg = wr; t.m2reg = ld; t.wmem = st;
        t.al = al; t.d = d; t.rd = rd; t.rdata = rdata;
        return t;
    endfunction

    // Data-memory responder: grants after the configured delay, returns load data later.
    initial begin
        cfg_t        c;
        req_t        r;
        bit          in_req = 0;
        int          gcnt = 0;
        int          rv_cnt = 0;
        int          cur_rw = 0;
        logic [31:0] cur_rdata = '0;
        dm_gnt = 0;
        dm_rvalid = 0;
        dm_rdata = '0;
        forever begin
            @(negedge clk);
            dm_gnt = 0;
            dm_rvalid = 0;
            if (pend) begin
                if (rv_cnt == 0) begin
                    dm_rvalid = 1;
                    dm_rdata  = cur_rdata;
                    pend      = 0;
                end else begin
                    rv_cnt--;
                end
            end else if (spur_force || (spur_en && $urandom_range(0, 3) == 0)) begin
                dm_rvalid = 1;
                dm_rdata  = spur_force ? 32'hFFFF_FFFF : $urandom;
            end
            if (dm_req && !clr) begin
                if (!in_req) begin
                    if (cfg_q.size() == 0) begin
                        chk("unexpected_dm_req", 104'd1, 104'd0);
                    end else begin
                        c = cfg_q.pop_front();
                        in_req = 1;
                        gcnt = c.gw;
                        cur_rw = c.rw;
                        cur_rdata = c.rdata;
                    end
                end
                if (in_req) begin
                    if (gcnt == 0) begin
                        dm_gnt = 1;
                        in_req = 0;
                        r = req_q.pop_front();
                        chk("dm_request", {39'd0, dm_we, dm_addr, dm_wdata},
                            {39'd0, r.we, r.addr, r.wdata});
                        if (!dm_we) begin
                            pend = 1;
                            rv_cnt = cur_rw;
                        end
                    end else begin
                        gcnt--;
                    end
                end
            end
        end
    end

    // Monitor: checks the W register after each retirement and after each bubble.
    initial begin
        instr_t      t;
        logic [31:0] m_wmo = '0;
        logic [31:0] m_load = '0;
        bit          retire_p = 0;
        bit          bubble_p = 0;
        forever begin
            @(negedge clk or posedge clr);
            if (clr) begin
                exp_q.delete();
                m_wmo = '0;
                m_load = '0;
                retire_p = 0;
                bubble_p = 0;
            end else begin
                if (retire_p) begin
                    if (exp_q.size() == 0) begin
                        chk("retire_without_instr", 104'd1, 104'd0);
                    end else begin
                        t = exp_q.pop_front();
                        if (t.m2reg || t.wmem) begin
                            if (!t.wmem) m_load = t.rdata;
                            m_wmo = m_load;
                        end
                        chk("w_retire", {33'd0, wwreg, wm2reg, wal, wrd, wmo},
                            {33'd0, t.wreg, t.m2reg, t.al, t.rd, m_wmo});
                    end
                end
                if (bubble_p) begin
                    chk("w_bubble", {102'd0, wwreg, wm2reg}, 104'd0);
                end
                retire_p = !mstall && busy;
                bubble_p = mstall;
            end
        end
    end

    // Stimulus: reset checks, directed scenarios, reset mid-access, random traffic.
    initial begin
        instr_t t;
        int     k;
        clr = 1;
        mwreg = 0; mm2reg = 0; mwmem = 0;
        mal = '0; md = '0; mrd = '0;
        #5;
        chk("reset_w_zero", {33'd0, wwreg, wm2reg, wal, wrd, wmo}, 104'd0);
        chk("reset_idle_noreq", {102'd0, dm_req, mstall}, 104'd0);
        mm2reg = 1; mal = 32'h44; #1;
        chk("reset_load_req", {101'd0, dm_req, dm_we, mstall}, {101'd0, 3'b101});
        mwmem = 1; #1;
        chk("reset_store_req", {101'd0, dm_req, dm_we, mstall}, {101'd0, 3'b111});
        mm2reg = 0; mwmem = 0; mal = '0;
        @(posedge clk);
        @(posedge clk);
        #2 clr = 0;
        @(posedge clk);
        #1;

        issue(mk(1, 0, 0, 32'h1234, 32'h0, 5'd5, 32'h0), 0, 0, "alu_op");
        spur_force = 1;
        issue(mk(1, 0, 0, 32'h5678, 32'h0, 5'd3, 32'h0), 0, 0, "alu_spurious_rvalid");
        spur_force = 0;
        issue(mk(0, 0, 1, 32'h100, 32'hDEADBEEF, 5'd0, 32'h0), 2, 0, "store_gnt_late");
        issue(mk(1, 1, 0, 32'h200, 32'h0, 5'd7, 32'hCAFEF00D), 0, 2, "load_rvalid_late");
        issue(mk(1, 1, 0, 32'h300, 32'h0, 5'd9, 32'h1357_9BDF), 0, 0, "b2b_load");
        issue(mk(0, 0, 1, 32'h304, 32'hA5A5_5A5A, 5'd0, 32'h0), 0, 0, "b2b_store");
        issue(mk(1, 1, 1, 32'h308, 32'h0BAD_F00D, 5'd4, 32'h0), 1, 0, "store_priority");

        // Reset while the load waits for data; its late read data must be ignored.
        drive_instr(mk(1, 1, 0, 32'h400, 32'h0, 5'd11, 32'h7777_7777), 0, 3);
        @(negedge clk);
        @(posedge clk);
        #2 clr = 1;
        #1;
        chk("clr_w_zero", {33'd0, wwreg, wm2reg, wal, wrd, wmo}, 104'd0);
        chk("clr_idle_req", {102'd0, dm_req, mstall}, {102'd0, 2'b11});
        drive_instr(mk(0, 0, 0, 32'h11, 32'h0, 5'd1, 32'h0), 0, 0);
        #3 clr = 0;
        wait_done(0, "post_clr_alu");
        for (int i = 0; i < 5; i++) begin
            issue(mk(1, 0, 0, 32'h20 + i, 32'h0, 5'(i + 2), 32'h0), 0, 0, "post_clr_alu_n");
        end
        issue(mk(1, 1, 0, 32'h500, 32'h0, 5'd12, 32'h2468_ACE0), 1, 1, "post_clr_load");

        spur_en = 1;
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 3);
            t.al = $urandom;
            t.d = $urandom;
            t.rd = 5'($urandom_range(0, 31));
            t.rdata = $urandom;
            t.wreg = 1'($urandom_range(0, 1));
            t.m2reg = 0;
            t.wmem = 0;
            if (k == 2) begin
                t.wreg = 1;
                t.m2reg = 1;
            end else if (k == 3) begin
                t.wmem = 1;
                t.m2reg = 1'($urandom_range(0, 1));
            end
            issue(t, $urandom_range(0, 2), $urandom_range(0, 3), "random");
        end
        spur_en = 0;
        busy = 0;
        mwreg = 0; mm2reg = 0; mwmem = 0;
        repeat (3) @(negedge clk);
        chk("exp_queue_drained", 104'(exp_q.size()), 104'd0);
        chk("req_queue_drained", 104'(req_q.size() + cfg_q.size()), 104'd0);
        $display("Result: errors=%0d of %0d checks", nerr, ncheck);
        $finish;
    end

endmodule

// File: doc/pl_mem_access.md
PL_MEM_ACCESS -- requirements
Module: pl_mem_access

Interface
REQ-001 clk  in  1  single pipeline clock; all state updates on rising edge.
REQ-002 clr  in  1  reset, asynchronous, active-high.
REQ-003 mwreg, mm2reg, mwmem  in  1 each  M-stage controls: reg write, load, store.
REQ-004 mal  in  32  M-stage ALU result and memory address; md  in  32  store data; mrd  in  5  destination register.
REQ-005 dm_req  out  1  data-memory request valid; dm_we  out  1  request is a store.
REQ-006 dm_addr  out  32  request address; dm_wdata  out  32  store data.
REQ-007 dm_gnt  in  1  memory accepts the request this cycle.
REQ-008 dm_rvalid  in  1  load data valid; dm_rdata  in  32  load data.
REQ-009 mstall  out  1  hold IF/ID/EX/M registers this cycle.
REQ-010 wwreg, wm2reg  out  1 each  W-stage controls; wmo  out  32  load data; wal  out  32  ALU result; wrd  out  5  destination.

Function
REQ-011 Memory op = mm2reg | mwmem; mwmem has priority if both set (treated as store).
REQ-012 FSM states: IDLE, WAIT, DONE.
REQ-013 IDLE, no memory op: dm_req=0, mstall=0; W register loads M inputs at the edge (wmo keeps its value).
REQ-014 IDLE, memory op: dm_req=1, dm_we=mwmem, dm_addr=mal, dm_wdata=md (combinational from inputs), mstall=1, W loads bubble.
REQ-015 IDLE, memory op, dm_gnt=0: remain IDLE; request held until granted.
REQ-016 IDLE, store, dm_gnt=1: next DONE.
REQ-017 IDLE, load, dm_gnt=1: next WAIT.
REQ-018 WAIT: dm_req=0, mstall=1, W loads bubble; on dm_rvalid=1 capture dm_rdata into load buffer, next DONE; else stay WAIT (no timeout).
REQ-019 DONE: dm_req=0, mstall=0; W loads wwreg=mwreg, wm2reg=mm2reg, wal=mal, wrd=mrd, wmo=load buffer; next IDLE.
REQ-020 dm_rvalid outside WAIT (including same cycle as grant in IDLE) is ignored.
REQ-021 Bubble = wwreg=0, wm2reg=0; wal, wrd, wmo unchanged.
REQ-022 Minimum latency: store 2 cycles (IDLE+DONE); load 3 cycles plus memory wait; non-memory op 1 cycle.
REQ-023 Upstream holds M inputs stable while mstall=1; block does not re-sample them.
REQ-024 Back-to-back memory ops: DONE returns to IDLE, next op issues dm_req in that IDLE cycle.

Reset
REQ-025 clr=1 forces state IDLE and clears wwreg, wm2reg, wmo, wal, wrd and load buffer to 0, independent of clk.
REQ-026 Reset during WAIT or DONE abandons the access; a later dm_rvalid is ignored per REQ-020.
REQ-027 dm_req, mstall follow REQ-013/014 from IDLE during and after reset (combinational on inputs).

Structure
REQ-028 Shared package pl_pkg holds state encodings (IDLE=2'd0, WAIT=2'd1, DONE=2'd2), data width 32, register-index width 5.
REQ-029 W-stage register is sub-module pl_reg_mw with load and bubble inputs; FSM and request logic are in pl_mem_access.

Verification
REQ-030 ALU op mwreg=1, mal=0x1234, mrd=5, no memory op -> next edge wwreg=1, wal=0x1234, wrd=5, mstall=0 throughout.
REQ-031 Store mal=0x100, md=0xDEADBEEF, dm_gnt low 2 cycles then high -> dm_req=1, dm_we=1 for 3 cycles, mstall=1 for 3, DONE then wwreg=0.
REQ-032 Load mal=0x200, mrd=7, gnt at cycle 0, rvalid with 0xCAFEF00D 3 cycles later -> wmo=0xCAFEF00D, wm2reg=1, wrd=7 after DONE; mstall=1 for 4 cycles.
REQ-033 Spurious dm_rvalid=1, dm_rdata=0xFFFFFFFF in IDLE with ALU op -> wmo unchanged.
REQ-034 Assert clr in WAIT -> immediate zero W outputs; following dm_rvalid ignored; next load completes normally.
REQ-035 Load then store back-to-back, immediate gnt/rvalid -> load completes in 3 cycles, store in next 2, no lost or duplicate dm_req.
